// File: rtl/sd_data_receive_pkg.sv
// Shared definitions for the SD DAT-line receive path.
// Holds the receiver state encoding, the CRC16 constants and a
// single-bit CRC16 update helper. The per-lane CRC and the top
// receiver both use them.
package sd_data_receive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_DATA,
        ST_CRC,
        ST_END
    } rx_state_e;

    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
    localparam int          SD_CRC_LEN    = 16;

    // One CCITT step. The incoming bit is XORed with the current MSB
    // to form the feedback term.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_data_receive_if.sv
// Host-side bundle of the SD data receiver: the transfer request and
// configuration, the received byte stream and the transfer status.
//   master : host/FSM side (drives start and configuration)
//   slave  : receiver side (drives data and status)
interface sd_data_receive_if #(
    parameter int BLK_LEN_W = 10
);
    logic                 start;
    logic                 wide_bus;
    logic [BLK_LEN_W-1:0] block_len;
    logic [15:0]          block_count;
    logic [7:0]           data_out;
    logic                 data_valid;
    logic                 block_done;
    logic                 done;
    logic                 busy;
    logic                 crc_err;
    logic                 frame_err;
    logic                 timeout_err;
    logic [15:0]          blocks_rcvd;

    modport master (
        output start, wide_bus, block_len, block_count,
        input  data_out, data_valid, block_done, done, busy,
               crc_err, frame_err, timeout_err, blocks_rcvd
    );

    modport slave (
        input  start, wide_bus, block_len, block_count,
        output data_out, data_valid, block_done, done, busy,
               crc_err, frame_err, timeout_err, blocks_rcvd
    );
endinterface

// File: rtl/sd_crc16_lane.sv
// Serial CRC16 (CCITT, init 0) for one DAT lane.
// Ports: clk, reset (sync, active high), clear (zero the CRC),
// enable (absorb bit_in this cycle), bit_in, crc (current remainder).
module sd_crc16_lane
    import sd_data_receive_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  bit_in,
    output logic [SD_CRC_LEN-1:0] crc
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_data_receive.sv
// SD DAT-line block receiver, 1-bit or 4-bit bus, on ex_clk only.
// Ports: ex_clk, reset (sync, active high), sd_clk_rise (card clock
// strobe; the only cycles on which DAT is sampled), sd_dat_pin (DAT
// lanes), host (sd_data_receive_if.slave: start/config in, byte
// stream and status out).
//
// state         | meaning
// --------------+-------------------------------------------------
// ST_IDLE       | waiting for start
// ST_WAIT_START | looking for the start bit, timeout running
// ST_DATA       | shifting in block_len bytes, lane CRCs running
// ST_CRC        | comparing 16 received CRC bits per used lane
// ST_END        | checking the end bit, block/transfer completion
module sd_data_receive
    import sd_data_receive_pkg::*;
#(
    parameter int MAX_DAT_WIDTH   = 4,
    parameter int MAX_BLOCK_BYTES = 512,
    parameter int TIMEOUT_CLKS    = 65535,
    parameter int BLK_LEN_W       = 10
) (
    input  logic                     ex_clk,
    input  logic                     reset,
    input  logic                     sd_clk_rise,
    input  logic [MAX_DAT_WIDTH-1:0] sd_dat_pin,
    sd_data_receive_if.slave         host
);

    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

    rx_state_e            state_q, state_d;
    logic                 wide_q, wide_d;
    logic [BLK_LEN_W-1:0] len_q, len_d, byte_q, byte_d;
    logic [15:0]          count_q, count_d, blocks_q, blocks_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [3:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d, data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d, block_done_q, block_done_d;
    logic                 done_q, done_d, busy_q, busy_d;
    logic                 crc_err_q, crc_err_d, frame_err_q, frame_err_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                  crc_clr, crc_en, start_bit, crc_miss, end_bad;
    logic [3:0]            dat4, used, crc_idx;
    logic [SD_CRC_LEN-1:0] lane_crc [MAX_DAT_WIDTH];

    // Pad to four lanes so the datapath is the same for both builds;
    // in 1-bit mode only lane 0 is ever marked used.
    assign dat4      = 4'(sd_dat_pin);
    assign used      = wide_q ? 4'hF : 4'h1;
    assign start_bit = wide_q ? (dat4 == 4'b0000) : !dat4[0];
    assign crc_idx   = ~bit_q;  // 15 - bit_q: CRC arrives MSB first

    for (genvar g = 0; g < MAX_DAT_WIDTH; g++) begin : g_lane
        sd_crc16_lane u_crc (
            .clk    (ex_clk),
            .reset  (reset),
            .clear  (crc_clr),
            .enable (crc_en && used[g]),
            .bit_in (dat4[g]),
            .crc    (lane_crc[g])
        );
    end

    always_comb begin
        crc_miss = 1'b0;
        end_bad  = 1'b0;
        for (int i = 0; i < MAX_DAT_WIDTH; i++) begin
            if (used[i] && (dat4[i] != lane_crc[i][crc_idx])) crc_miss = 1'b1;
            if (used[i] && !dat4[i]) end_bad = 1'b1;
        end
    end

    always_ff @(posedge ex_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wide_q        <= 1'b0;
            len_q         <= '0;
            count_q       <= '0;
            tmo_q         <= '0;
            byte_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            block_done_q  <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            crc_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            blocks_q      <= '0;
        end else begin
            state_q       <= state_d;
            wide_q        <= wide_d;
            len_q         <= len_d;
            count_q       <= count_d;
            tmo_q         <= tmo_d;
            byte_q        <= byte_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            block_done_q  <= block_done_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            crc_err_q     <= crc_err_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            blocks_q      <= blocks_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wide_d        = wide_q;
        len_d         = len_q;
        count_d       = count_q;
        tmo_d         = tmo_q;
        byte_d        = byte_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        block_done_d  = 1'b0;
        done_d        = 1'b0;
        busy_d        = busy_q;
        crc_err_d     = crc_err_q;
        frame_err_d   = frame_err_q;
        timeout_err_d = timeout_err_q;
        blocks_d      = blocks_q;
        crc_clr       = 1'b0;
        crc_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // done_q marks the cycle a transfer just ended; a start
                // landing there is dropped.
                if (host.start && !done_q) begin
                    wide_d        = host.wide_bus && (MAX_DAT_WIDTH == 4);
                    len_d         = (host.block_len == '0) ? BLK_LEN_W'(MAX_BLOCK_BYTES)
                                                           : host.block_len;
                    count_d       = (host.block_count == 16'd0) ? 16'd1 : host.block_count;
                    crc_err_d     = 1'b0;
                    frame_err_d   = 1'b0;
                    timeout_err_d = 1'b0;
                    blocks_d      = '0;
                    tmo_d         = '0;
                    busy_d        = 1'b1;
                    state_d       = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (sd_clk_rise) begin
                    if (start_bit) begin
                        crc_clr = 1'b1;
                        bit_d   = '0;
                        byte_d  = '0;
                        state_d = ST_DATA;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
                        timeout_err_d = 1'b1;
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (sd_clk_rise) begin
                    crc_en  = 1'b1;
                    shift_d = wide_q ? {shift_q[3:0], dat4} : {shift_q[6:0], dat4[0]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == (wide_q ? 4'd1 : 4'd7)) begin
                        bit_d        = '0;
                        data_out_d   = shift_d;
                        data_valid_d = 1'b1;
                        byte_d       = byte_q + BLK_LEN_W'(1);
                        if (byte_q == len_q - BLK_LEN_W'(1)) state_d = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (sd_clk_rise) begin
                    if (crc_miss) crc_err_d = 1'b1;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'(SD_CRC_LEN - 1)) state_d = ST_END;
                end
            end
            ST_END: begin
                if (sd_clk_rise) begin
                    if (end_bad) frame_err_d = 1'b1;
                    if (end_bad || crc_err_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        block_done_d = 1'b1;
                        blocks_d     = blocks_q + 16'd1;
                        if (blocks_d == count_q) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            tmo_d   = '0;
                            state_d = ST_WAIT_START;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign host.data_out    = data_out_q;
    assign host.data_valid  = data_valid_q;
    assign host.block_done  = block_done_q;
    assign host.done        = done_q;
    assign host.busy        = busy_q;
    assign host.crc_err     = crc_err_q;
    assign host.frame_err   = frame_err_q;
    assign host.timeout_err = timeout_err_q;
    assign host.blocks_rcvd = blocks_q;

endmodule

// File: tb/tb_sd_data_receive.sv
// Directed bench for sd_data_receive: card-side DAT driver with a CRC16
// reference, an output monitor collecting bytes and pulses, and
// hand-derived expectations per case.
module tb_sd_data_receive;

    logic       ex_clk      = 1'b0;
    logic       reset       = 1'b1;
    logic       sd_clk_rise = 1'b0;
    logic [3:0] sd_dat_pin  = 4'hF;

    sd_data_receive_if #(.BLK_LEN_W(10)) host_if ();

    sd_data_receive #(
        .MAX_DAT_WIDTH   (4),
        .MAX_BLOCK_BYTES (512),
        .TIMEOUT_CLKS    (16),
        .BLK_LEN_W       (10)
    ) dut (
        .ex_clk      (ex_clk),
        .reset       (reset),
        .sd_clk_rise (sd_clk_rise),
        .sd_dat_pin  (sd_dat_pin),
        .host        (host_if)
    );

    always #5 ex_clk = ~ex_clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_bd     = 0;
    int          n_done   = 0;
    logic [7:0]  rx_q [$];
    logic [15:0] m_crc [4];

    always @(negedge ex_clk) begin
        if (!reset) begin
            if (host_if.data_valid) rx_q.push_back(host_if.data_out);
            if (host_if.block_done) n_bd++;
            if (host_if.done) n_done++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = {c[14:0], 1'b0};
        if (c[15] ^ b) r = r ^ 16'h1021;
        return r;
    endfunction

    task automatic tick(input logic rise, input logic [3:0] dat);
        sd_clk_rise = rise;
        sd_dat_pin  = dat;
        @(posedge ex_clk);
        #1;
        sd_clk_rise = 1'b0;
    endtask

    task automatic sd_strobe(input logic [3:0] dat);
        tick(1'b1, dat);
        tick(1'b0, dat);
    endtask

    task automatic do_start(input logic w, input logic [9:0] len, input logic [15:0] cnt);
        host_if.wide_bus    = w;
        host_if.block_len   = len;
        host_if.block_count = cnt;
        rx_q.delete();
        n_bd   = 0;
        n_done = 0;
        host_if.start = 1'b1;
        tick(1'b0, 4'hF);
        host_if.start = 1'b0;
    endtask

    task automatic send_start(input logic w);
        for (int l = 0; l < 4; l++) m_crc[l] = 16'h0000;
        sd_strobe(w ? 4'b0000 : 4'b1110);
    endtask

    task automatic send_byte(input logic w, input logic [7:0] b);
        logic [3:0] nib;
        if (w) begin
            for (int h = 1; h >= 0; h--) begin
                nib = (h == 1) ? b[7:4] : b[3:0];
                sd_strobe(nib);
                for (int l = 0; l < 4; l++) m_crc[l] = ref_crc(m_crc[l], nib[l]);
            end
        end else begin
            for (int k = 7; k >= 0; k--) begin
                sd_strobe({3'b111, b[k]});
                m_crc[0] = ref_crc(m_crc[0], b[k]);
            end
        end
    endtask

    task automatic send_crc(input logic w, input logic flip0);
        logic [3:0] d;
        for (int i = 15; i >= 0; i--) begin
            if (w) d = {m_crc[3][i], m_crc[2][i], m_crc[1][i], m_crc[0][i]};
            else   d = {3'b111, m_crc[0][i]};
            if (flip0 && i == 0) d[0] = ~d[0];
            sd_strobe(d);
        end
    endtask

    task automatic finish_xfer(input logic [3:0] end_pat);
        sd_strobe(end_pat);
        tick(1'b0, 4'hF);
    endtask

    function automatic int count_not(input logic [7:0] v);
        int n = 0;
        foreach (rx_q[i]) if (rx_q[i] !== v) n++;
        return n;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] c2 [4];
        logic [7:0] c6 [3];
        int         ns;
        c2[0] = 8'h12; c2[1] = 8'h34; c2[2] = 8'h56; c2[3] = 8'h78;
        c6[0] = 8'h00; c6[1] = 8'h80; c6[2] = 8'h01;
        host_if.start       = 1'b0;
        host_if.wide_bus    = 1'b0;
        host_if.block_len   = '0;
        host_if.block_count = '0;

        repeat (3) tick(1'b0, 4'hF);
        check("rst_data_out",   host_if.data_out,    0);
        check("rst_data_valid", host_if.data_valid,  0);
        check("rst_block_done", host_if.block_done,  0);
        check("rst_done",       host_if.done,        0);
        check("rst_busy",       host_if.busy,        0);
        check("rst_errs",       {host_if.crc_err, host_if.frame_err, host_if.timeout_err}, 0);
        check("rst_blocks",     host_if.blocks_rcvd, 0);
        reset = 1'b0;
        tick(1'b0, 4'hF);

        // Case 1: 512 x 0xFF, 1-bit, fixed CRC 0x7FA1
        do_start(1'b0, 10'd512, 16'd1);
        check("c1_busy_after_start", host_if.busy, 1);
        send_start(1'b0);
        for (int i = 0; i < 512; i++) send_byte(1'b0, 8'hFF);
        m_crc[0] = 16'h7FA1;
        send_crc(1'b0, 1'b0);
        finish_xfer(4'hF);
        check("c1_nbytes",    rx_q.size(), 512);
        check("c1_bad_bytes", count_not(8'hFF), 0);
        check("c1_block_done", n_bd, 1);
        check("c1_done",      n_done, 1);
        check("c1_crc_err",   host_if.crc_err, 0);
        check("c1_frame_err", host_if.frame_err, 0);
        check("c1_blocks",    host_if.blocks_rcvd, 1);
        check("c1_busy",      host_if.busy, 0);

        // Case 2: 2 blocks of 4 bytes, 4-bit bus
        do_start(1'b1, 10'd4, 16'd2);
        for (int b = 0; b < 2; b++) begin
            sd_strobe(4'hF);
            send_start(1'b1);
            for (int i = 0; i < 4; i++) send_byte(1'b1, c2[i]);
            send_crc(1'b1, 1'b0);
            finish_xfer(4'hF);
            if (b == 0) begin
                check("c2_mid_busy",   host_if.busy, 1);
                check("c2_mid_done",   n_done, 0);
                check("c2_mid_blocks", host_if.blocks_rcvd, 1);
            end
        end
        check("c2_nbytes", rx_q.size(), 8);
        for (int i = 0; i < 8 && i < rx_q.size(); i++) check("c2_byte", rx_q[i], c2[i % 4]);
        check("c2_block_done", n_bd, 2);
        check("c2_done",       n_done, 1);
        check("c2_blocks",     host_if.blocks_rcvd, 2);
        check("c2_crc_err",    host_if.crc_err, 0);
        check("c2_busy",       host_if.busy, 0);

        // Case 3: as case 1 with block_len=0 (=512) and DAT0 CRC bit 0 flipped
        do_start(1'b0, 10'd0, 16'd1);
        send_start(1'b0);
        for (int i = 0; i < 512; i++) send_byte(1'b0, 8'hFF);
        m_crc[0] = 16'h7FA1;
        send_crc(1'b0, 1'b1);
        finish_xfer(4'hF);
        check("c3_nbytes",     rx_q.size(), 512);
        check("c3_crc_err",    host_if.crc_err, 1);
        check("c3_frame_err",  host_if.frame_err, 0);
        check("c3_done",       n_done, 1);
        check("c3_block_done", n_bd, 0);
        check("c3_blocks",     host_if.blocks_rcvd, 0);
        check("c3_busy",       host_if.busy, 0);

        // Case 4: start-bit timeout after 16 strobes
        do_start(1'b0, 10'd4, 16'd1);
        check("c4_crc_err_cleared", host_if.crc_err, 0);
        ns = 0;
        while (n_done == 0 && ns < 40) begin
            sd_strobe(4'hF);
            ns++;
        end
        check("c4_strobes_to_done", ns, 16);
        check("c4_timeout_err",     host_if.timeout_err, 1);
        check("c4_no_data",         rx_q.size(), 0);
        check("c4_busy",            host_if.busy, 0);

        // Case 5: partial-low start patterns ignored, bad end bit on DAT2
        do_start(1'b1, 10'd2, 16'd1);
        check("c5_timeout_cleared", host_if.timeout_err, 0);
        repeat (3) sd_strobe(4'b1110);
        send_start(1'b1);
        send_byte(1'b1, 8'hA5);
        send_byte(1'b1, 8'h3C);
        send_crc(1'b1, 1'b0);
        finish_xfer(4'b1011);
        check("c5_nbytes", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("c5_byte0", rx_q[0], 8'hA5);
            check("c5_byte1", rx_q[1], 8'h3C);
        end
        check("c5_frame_err",  host_if.frame_err, 1);
        check("c5_crc_err",    host_if.crc_err, 0);
        check("c5_done",       n_done, 1);
        check("c5_block_done", n_bd, 0);
        check("c5_blocks",     host_if.blocks_rcvd, 0);

        // Case 6: reset after 10 bytes, then a clean transfer (block_count=0 -> 1)
        do_start(1'b0, 10'd16, 16'd1);
        send_start(1'b0);
        for (int i = 0; i < 10; i++) send_byte(1'b0, 8'h5A + 8'(i));
        check("c6_pre_nbytes", rx_q.size(), 10);
        reset = 1'b1;
        repeat (2) tick(1'b0, 4'hF);
        check("c6_rst_busy",     host_if.busy, 0);
        check("c6_rst_data_out", host_if.data_out, 0);
        check("c6_rst_done",     host_if.done, 0);
        reset = 1'b0;
        repeat (2) tick(1'b0, 4'hF);
        check("c6_no_done",  n_done, 0);
        check("c6_rst_busy_after", host_if.busy, 0);
        do_start(1'b0, 10'd3, 16'd0);
        send_start(1'b0);
        for (int i = 0; i < 3; i++) send_byte(1'b0, c6[i]);
        send_crc(1'b0, 1'b0);
        finish_xfer(4'hF);
        check("c6_nbytes", rx_q.size(), 3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) check("c6_byte", rx_q[i], c6[i]);
        check("c6_block_done", n_bd, 1);
        check("c6_done",       n_done, 1);
        check("c6_blocks",     host_if.blocks_rcvd, 1);
        check("c6_errs",       {host_if.crc_err, host_if.frame_err, host_if.timeout_err}, 0);
        check("c6_busy",       host_if.busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
